// File: rtl/calc_keypad_pkg.sv
// Package: calc_keypad_pkg
// Shared types and constants for the calculator keypad scanner.
//   scan_state_t : scanner FSM states
//   KEY_*        : key indices (row*4+col) of the operator keys
//   DIGIT_KEY    : key index for decimal digits 0..9
//   low_row()    : index of the lowest low (pressed) row in an active-low pattern
//   multi_low()  : true when more than one row of an active-low pattern is low
package calc_keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, VALID, RELEASE} scan_state_t;

  localparam logic [3:0] KEY_ADD  = 4'd3;
  localparam logic [3:0] KEY_SUB  = 4'd7;
  localparam logic [3:0] KEY_MULT = 4'd11;
  localparam logic [3:0] KEY_EQ   = 4'd12;
  localparam logic [3:0] KEY_NEG  = 4'd15;

  // Indexed by the digit value: DIGIT_KEY[0] is the key for '0'.
  localparam logic [3:0] DIGIT_KEY [10] = '{4'd13, 4'd0, 4'd1, 4'd2, 4'd4,
                                            4'd5, 4'd6, 4'd8, 4'd9, 4'd10};

  // Iterating from the top down lets the lowest low row overwrite the result.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_low(input logic [3:0] rows);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, ~rows[i]};
    end
    return (cnt > 3'd1);
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Module: keypad_row_sync
// Two-flop synchroniser for the asynchronous keypad row inputs.
//   clk      : system clock
//   nRST     : asynchronous active-low reset (outputs idle-high 4'hF)
//   row_in   : raw keypad rows, active low, asynchronous
//   row_sync : rows retimed into the clk domain
module keypad_row_sync (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] row_in,
  output logic [3:0] row_sync
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      meta     <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      meta     <= row_in;
      row_sync <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Module: keypad_scan_ctrl
// Scans a 4x4 active-low keypad one column at a time, debounces a press,
// offers the key code once over a valid/read handshake, then waits for a
// debounced release before scanning again.
//   clk         : system clock
//   nRST        : asynchronous active-low reset
//   RowIn       : keypad rows, active low, asynchronous
//   ColOut      : keypad columns, one-cold
//   key_code    : row*4+col of the accepted key, valid while key_valid=1
//   key_valid   : debounced key available
//   key_read    : consumer accepts key_code
//   key_pressed : high from acceptance until the release is debounced
// Parameters: SCAN_DIV (clocks per column, >=3), DEBOUNCE_CYC (>=1).
// Build option: KEYPAD_MULTI_REJECT_EN - when defined, several low rows
// at once count as no press (and as a mismatch while debouncing).
module keypad_scan_ctrl
  import calc_keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] RowIn,
  output logic [3:0] ColOut,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_read,
  output logic       key_pressed
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYC - 1);

  logic [3:0]    rs;
  scan_state_t   state;
  logic [1:0]    col;
  logic [1:0]    col_inc;
  logic [1:0]    row_idx;
  logic [3:0]    row_pat;
  logic [DW-1:0] dwell;
  logic [BW-1:0] deb_cnt;
  logic          press_hit;
  logic          deb_match;

  keypad_row_sync u_row_sync (
    .clk      (clk),
    .nRST     (nRST),
    .row_in   (RowIn),
    .row_sync (rs)
  );

  // Two-bit column index wraps 3 -> 0 on its own.
  assign col_inc = col + 2'd1;

`ifdef KEYPAD_MULTI_REJECT_EN
  assign press_hit = (rs != 4'hF) && !multi_low(rs);
  assign deb_match = (rs == row_pat) && !multi_low(rs);
`else
  assign press_hit = (rs != 4'hF);
  assign deb_match = (rs == row_pat);
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= SCAN;
      col         <= 2'd0;
      ColOut      <= 4'b1110;
      dwell       <= '0;
      deb_cnt     <= '0;
      row_idx     <= 2'd0;
      row_pat     <= 4'hF;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            // Last dwell clock: the synchronised rows have settled for this column.
            dwell <= '0;
            if (press_hit) begin
              row_idx <= low_row(rs);
              row_pat <= rs;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col    <= col_inc;
              ColOut <= ~(4'b0001 << col_inc);
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (!deb_match) begin
            // Bounce or glitch: retry the same column from a fresh dwell.
            state   <= SCAN;
            dwell   <= '0;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= VALID;
            key_valid   <= 1'b1;
            key_code    <= {row_idx, col};
            key_pressed <= 1'b1;
            deb_cnt     <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        VALID: begin
          // The code stays latched even if the key is let go before the read.
          if (key_read) begin
            key_valid <= 1'b0;
            deb_cnt   <= '0;
            state     <= RELEASE;
          end
        end

        RELEASE: begin
          if (rs != 4'hF) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            key_pressed <= 1'b0;
            col         <= col_inc;
            ColOut      <= ~(4'b0001 << col_inc);
            dwell       <= '0;
            deb_cnt     <= '0;
            state       <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CYC=8).
// A behavioural keypad drives RowIn from ColOut and the set of held keys.
// Expected codes are queued when a press is applied and popped when the
// DUT raises key_valid. Honours KEYPAD_MULTI_REJECT_EN for the two-row case.
module tb_keypad_scan_ctrl;
  import calc_keypad_pkg::*;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic [3:0] RowIn;
  logic [3:0] ColOut;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_read = 1'b0;
  logic       key_pressed;

  logic [15:0] keys = 16'h0000;
  logic        glitch_row0 = 1'b0;
  logic        valid_q = 1'b0;
  logic [3:0]  sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    bit          expv;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk         (clk),
    .nRST        (nRST),
    .RowIn       (RowIn),
    .ColOut      (ColOut),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_read    (key_read),
    .key_pressed (key_pressed)
  );

  // Physical keypad: a held key shorts its row to the driven-low column.
  always_comb begin
    RowIn = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[r*4+c] && !ColOut[c]) RowIn[r] = 1'b0;
      end
    end
    if (glitch_row0) RowIn[0] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every rising key_valid must match the oldest queued code.
  always @(negedge clk) begin
    if (nRST && key_valid && !valid_q) begin
      if (sb.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else check("sb_code", {28'd0, key_code}, {28'd0, sb.pop_front()});
    end
    valid_q <= nRST ? key_valid : 1'b0;
  end

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!key_pressed) break;
      @(negedge clk);
    end
    check("release_done", {31'd0, key_pressed}, 32'd0);
  endtask

  task automatic read_pulse();
    key_read = 1'b1;
    @(negedge clk);
    key_read = 1'b0;
    check("valid_drop", {31'd0, key_valid}, 32'd0);
  endtask

  task automatic do_key(input logic [15:0] k, input logic [3:0] code, input bit expv);
    bit seen;
    if (expv) sb.push_back(code);
    keys = k;
    wait_valid(expv ? 300 : 120, seen);
    check("valid_seen", {31'd0, seen}, {31'd0, expv});
    if (seen) begin
      check("tbl_code", {28'd0, key_code}, {28'd0, code});
      read_pulse();
    end
    keys = 16'h0000;
    wait_release(200);
    $display("key 0x%04h -> valid=%0d code=%0d", k, seen, key_code);
  endtask

  initial begin
    bit seen;
    int same;
    logic [3:0] col_prev;
    bit changed;

    tbl[0] = '{16'h0001, DIGIT_KEY[1], 1'b1};
    tbl[1] = '{16'h0002, DIGIT_KEY[2], 1'b1};
    tbl[2] = '{16'h0004, DIGIT_KEY[3], 1'b1};
    tbl[3] = '{16'h0008, KEY_ADD,      1'b1};
    tbl[4] = '{16'h0020, DIGIT_KEY[5], 1'b1};
    tbl[5] = '{16'h0400, DIGIT_KEY[9], 1'b1};
    tbl[6] = '{16'h2000, DIGIT_KEY[0], 1'b1};
    tbl[7] = '{16'h8000, KEY_NEG,      1'b1};
`ifdef KEYPAD_MULTI_REJECT_EN
    tbl[8] = '{16'h1001, 4'd0, 1'b0};
`else
    tbl[8] = '{16'h1001, 4'd0, 1'b1};
`endif

    // Reset values, then idle scan: each column 4 clocks, in order.
    repeat (3) @(negedge clk);
    check("rst_colout", {28'd0, ColOut}, 32'hE);
    check("rst_code", {28'd0, key_code}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_pressed", {31'd0, key_pressed}, 32'd0);
    nRST = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (n != 0) @(negedge clk);
      check("idle_colout", {28'd0, ColOut}, {28'd0, ~(4'b0001 << ((n / 4) % 4))});
      check("idle_valid", {31'd0, key_valid}, 32'd0);
    end
    $display("idle scan sequence checked");

    // key_read with nothing offered is ignored; then key 9 (row2, col1).
    read_pulse();
    sb.push_back(4'd9);
    keys = 16'h0200;
    wait_valid(300, seen);
    check("k9_seen", {31'd0, seen}, 32'd1);
    check("k9_code", {28'd0, key_code}, 32'd9);
    check("k9_colout", {28'd0, ColOut}, 32'hD);
    check("k9_pressed", {31'd0, key_pressed}, 32'd1);
    repeat (5) @(negedge clk);
    check("k9_hold", {31'd0, key_valid}, 32'd1);
    read_pulse();
    keys = 16'h0000;
    wait_release(200);
    check("k9_next_col", {28'd0, ColOut}, 32'hB);
    $display("key 9 handshake done, scan resumed at col2");

    // Three-clock glitch on row0: no key, scan must keep moving.
    glitch_row0 = 1'b1;
    repeat (3) @(negedge clk);
    glitch_row0 = 1'b0;
    col_prev = ColOut;
    changed = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (ColOut != col_prev) begin
        changed = 1'b1;
        break;
      end
    end
    check("glitch_scan_moves", {31'd0, changed}, 32'd1);
    repeat (30) @(negedge clk);
    check("glitch_no_valid", {31'd0, key_valid}, 32'd0);
    $display("row0 glitch rejected");

    // Key 12 released before a late read: code stays latched.
    sb.push_back(KEY_EQ);
    keys = 16'h1000;
    wait_valid(300, seen);
    check("k12_seen", {31'd0, seen}, 32'd1);
    keys = 16'h0000;
    repeat (50) @(negedge clk);
    check("k12_hold_valid", {31'd0, key_valid}, 32'd1);
    check("k12_hold_code", {28'd0, key_code}, 32'd12);
    read_pulse();
    check("k12_pressed_after_read", {31'd0, key_pressed}, 32'd1);
    repeat (7) @(negedge clk);
    check("k12_release_7", {31'd0, key_pressed}, 32'd1);
    @(negedge clk);
    check("k12_release_8", {31'd0, key_pressed}, 32'd0);
    $display("key 12 late read done");

    // Table of single presses and the two-row case.
    for (int t = 0; t < 9; t++) do_key(tbl[t].keys, tbl[t].code, tbl[t].expv);

    // Reset while debouncing key 4 (row1, col0).
    keys = 16'h0010;
    same = 0;
    for (int i = 0; i < 200 && same < 6; i++) begin
      @(negedge clk);
      same = (ColOut == 4'hE) ? same + 1 : 0;
    end
    check("deb_reached", {31'd0, (same >= 6)}, 32'd1);
    check("deb_no_valid", {31'd0, key_valid}, 32'd0);
    nRST = 1'b0;
    #1;
    check("deb_rst_colout", {28'd0, ColOut}, 32'hE);
    check("deb_rst_code", {28'd0, key_code}, 32'd0);
    check("deb_rst_pressed", {31'd0, key_pressed}, 32'd0);
    sb.push_back(4'd4);
    @(negedge clk);
    nRST = 1'b1;
    wait_valid(300, seen);
    check("deb_fresh_seen", {31'd0, seen}, 32'd1);
    check("deb_fresh_code", {28'd0, key_code}, 32'd4);
    read_pulse();
    keys = 16'h0000;
    wait_release(200);
    $display("reset during debounce recovered, key 4");

    // Reset while offering key 6 (row1, col2).
    sb.push_back(4'd6);
    keys = 16'h0040;
    wait_valid(300, seen);
    check("val_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    nRST = 1'b0;
    #1;
    check("val_rst_valid", {31'd0, key_valid}, 32'd0);
    check("val_rst_code", {28'd0, key_code}, 32'd0);
    check("val_rst_pressed", {31'd0, key_pressed}, 32'd0);
    check("val_rst_colout", {28'd0, ColOut}, 32'hE);
    sb.push_back(4'd6);
    @(negedge clk);
    nRST = 1'b1;
    wait_valid(300, seen);
    check("val_fresh_seen", {31'd0, seen}, 32'd1);
    check("val_fresh_code", {28'd0, key_code}, 32'd6);
    read_pulse();
    keys = 16'h0000;
    wait_release(200);
    $display("reset during valid recovered, key 6");

    repeat (40) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
